vga_controlador_param: RTL and testbench

VGA_CONTROLADOR_PARAM -- requirements
Module: vga_controlador_param

---
 rtl/vga_param_pkg.sv | 34 +++
 rtl/vga_contador_sync.sv | 59 +++++
 rtl/vga_controlador_param.sv | 127 ++++++++++++
 tb/tb_vga_controlador_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_param_pkg.sv
// Shared VGA timing defaults, derived frame totals and the sync-window helper.
package vga_param_pkg;

    localparam int CNT_W       = 11;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYN   = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYN   = 2;
    localparam int DEF_V_BP    = 33;

    // Raw timing flags as issued with the scan coordinate; true means "active".
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_raw_t;

    function automatic int h_tot(input int act, input int fp, input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

    function automatic int v_tot(input int act, input int fp, input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

    function automatic logic sync_active(input logic [CNT_W-1:0] cnt, input int lo, input int len);
        return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/vga_contador_sync.sv
// Pixel-rate divider and horizontal/vertical scan counters.
module vga_contador_sync
    import vga_param_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_TOT   = 800,
    parameter int V_TOT   = 525
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             tick_o,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o,
    output logic             frame_end_o
);

    localparam logic [4:0]       DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);

    logic [4:0]       div_q, div_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             tick, h_wrap, v_wrap;

    // With CLK_DIV=1 the divider stays at 0, which is also its last value.
    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_wrap = (hcnt_q == H_LAST);
        v_wrap = (vcnt_q == V_LAST);
        div_d  = tick ? 5'd0 : div_q + 5'd1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + CNT_W'(1);
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign tick_o      = tick;
    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign frame_end_o = tick && h_wrap && v_wrap;

endmodule

// File: rtl/vga_controlador_param.sv
// Parameterised VGA controller: scan counters, renderer-latency delay line, aligned outputs, blink.
module vga_controlador_param
    import vga_param_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYN    = DEF_H_SYN,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYN    = DEF_V_SYN,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int COLOR_W  = 8,
    parameter int PIPE_LAT = 1,
    parameter int BLINK_FR = 30
) (
    input  logic               reloj_nexys,
    input  logic               reset_total,
    input  logic [COLOR_W-1:0] color_in,
    output logic               pixel_tick,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               frame_start,
    output logic               blink,
    output logic               hsincro,
    output logic               vsincro,
    output logic [COLOR_W-1:0] color_salida
);

    localparam int   H_TOT   = h_tot(H_ACT, H_FP, H_SYN, H_BP);
    localparam int   V_TOT   = v_tot(V_ACT, V_FP, V_SYN, V_BP);
    localparam logic HS_ACT  = (H_POL != 0);
    localparam logic VS_ACT  = (V_POL != 0);
    localparam int   FR_W    = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FR - 1);

    logic             tick, frame_end;
    logic [CNT_W-1:0] hcnt, vcnt;
    vga_raw_t         raw, dly;

    vga_contador_sync #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (H_TOT),
        .V_TOT   (V_TOT)
    ) u_cnt (
        .clk_i       (reloj_nexys),
        .rst_ni      (reset_total),
        .tick_o      (tick),
        .hcnt_o      (hcnt),
        .vcnt_o      (vcnt),
        .frame_end_o (frame_end)
    );

    always_comb begin
        raw.hs = sync_active(hcnt, H_ACT + H_FP, H_SYN);
        raw.vs = sync_active(vcnt, V_ACT + V_FP, V_SYN);
        raw.de = (hcnt < CNT_W'(H_ACT)) && (vcnt < CNT_W'(V_ACT));
    end

    // Timing flags wait here for the renderer to deliver the matching colour.
    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign dly = raw;
        end else begin : g_pipe
            vga_raw_t stage_q [PIPE_LAT];
            always_ff @(posedge reloj_nexys or negedge reset_total) begin
                if (!reset_total) begin
                    for (int i = 0; i < PIPE_LAT; i++) stage_q[i] <= '0;
                end else if (tick) begin
                    stage_q[0] <= raw;
                    for (int i = 1; i < PIPE_LAT; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign dly = stage_q[PIPE_LAT-1];
        end
    endgenerate

    logic [COLOR_W-1:0] color_q, color_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic [FR_W-1:0]    fr_q, fr_d;
    logic               blink_q, blink_d;

    always_comb begin
        color_d = dly.de ? color_in : '0;
        hs_d    = ~(dly.hs ^ HS_ACT);
        vs_d    = ~(dly.vs ^ VS_ACT);
        fr_d    = fr_q;
        blink_d = blink_q;
        if (frame_end) begin
            if (fr_q == FR_LAST) begin
                fr_d    = '0;
                blink_d = ~blink_q;
            end else begin
                fr_d = fr_q + FR_W'(1);
            end
        end
    end

    always_ff @(posedge reloj_nexys or negedge reset_total) begin
        if (!reset_total) begin
            color_q <= '0;
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
            fr_q    <= '0;
            blink_q <= 1'b0;
        end else if (tick) begin
            color_q <= color_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fr_q    <= fr_d;
            blink_q <= blink_d;
        end
    end

    assign pixel_tick   = tick;
    assign pixel_x      = hcnt;
    assign pixel_y      = vcnt;
    assign frame_start  = frame_end;
    assign blink        = blink_q;
    assign hsincro      = hs_q;
    assign vsincro      = vs_q;
    assign color_salida = color_q;

endmodule

// File: tb/tb_vga_controlador_param.sv
// Directed bench for vga_controlador_param: default, small/pipelined and fast/active-high instances.
module tb_vga_controlador_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] cin0 = 8'h00, cin1 = 8'h00, cin2 = 8'h00;

    logic        tick0, tick1, tick2, fs0, fs1, fs2, bl0, bl1, bl2;
    logic        hs0, hs1, hs2, vs0, vs1, vs2;
    logic [10:0] x0, x1, x2, y0, y1, y2;
    logic [7:0]  col0, col1, col2;

    int total = 0;
    int bad   = 0;

    initial forever #5 clk = ~clk;

    vga_controlador_param u0 (
        .reloj_nexys(clk), .reset_total(rst_n), .color_in(cin0),
        .pixel_tick(tick0), .pixel_x(x0), .pixel_y(y0), .frame_start(fs0), .blink(bl0),
        .hsincro(hs0), .vsincro(vs0), .color_salida(col0));

    vga_controlador_param #(
        .CLK_DIV(2), .H_ACT(8), .H_FP(2), .H_SYN(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYN(2), .V_BP(1), .PIPE_LAT(2), .BLINK_FR(2)
    ) u1 (
        .reloj_nexys(clk), .reset_total(rst_n), .color_in(cin1),
        .pixel_tick(tick1), .pixel_x(x1), .pixel_y(y1), .frame_start(fs1), .blink(bl1),
        .hsincro(hs1), .vsincro(vs1), .color_salida(col1));

    vga_controlador_param #(
        .CLK_DIV(1), .H_ACT(8), .H_FP(2), .H_SYN(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYN(2), .V_BP(1), .H_POL(1), .V_POL(1), .PIPE_LAT(0)
    ) u2 (
        .reloj_nexys(clk), .reset_total(rst_n), .color_in(cin2),
        .pixel_tick(tick2), .pixel_x(x2), .pixel_y(y2), .frame_start(fs2), .blink(bl2),
        .hsincro(hs2), .vsincro(vs2), .color_salida(col2));

    // Renderer model for u1: returns the x issued two ticks earlier.
    initial forever begin
        @(negedge clk);
        cin1 = x1[7:0] - 8'd2;
    end

    typedef struct {
        int         dut;
        int         x;
        int         y;
        logic [7:0] cin;
        logic       hs;
        logic       vs;
        logic [7:0] col;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input int x, input int y, input logic [7:0] c,
                       input logic h, input logic v, input logic [7:0] col);
        vec_t e;
        e.dut = d; e.x = x; e.y = y; e.cin = c; e.hs = h; e.vs = v; e.col = col;
        tbl.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting, got none, expected event", nm);
    endtask

    function automatic logic [10:0] get_x(input int d);
        case (d) 0: return x0; 1: return x1; default: return x2; endcase
    endfunction
    function automatic logic [10:0] get_y(input int d);
        case (d) 0: return y0; 1: return y1; default: return y2; endcase
    endfunction
    function automatic logic get_hs(input int d);
        case (d) 0: return hs0; 1: return hs1; default: return hs2; endcase
    endfunction
    function automatic logic get_vs(input int d);
        case (d) 0: return vs0; 1: return vs1; default: return vs2; endcase
    endfunction
    function automatic logic [7:0] get_col(input int d);
        case (d) 0: return col0; 1: return col1; default: return col2; endcase
    endfunction
    function automatic logic get_fs(input int d);
        case (d) 0: return fs0; 1: return fs1; default: return fs2; endcase
    endfunction

    task automatic wait_pos(input int d, input int x, input int y, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (get_x(d) == 11'(x) && get_y(d) == 11'(y)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fs(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (get_fs(d)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;

        // u0: defaults, PIPE_LAT=1, sync offset 2 ticks
        add(0,   1, 0, 8'hA5, 1, 1, 8'h00);
        add(0,   2, 0, 8'hA5, 1, 1, 8'hA5);
        add(0, 100, 0, 8'h3C, 1, 1, 8'h3C);
        add(0, 641, 0, 8'h3C, 1, 1, 8'h3C);
        add(0, 642, 0, 8'h3C, 1, 1, 8'h00);
        add(0, 657, 0, 8'h3C, 1, 1, 8'h00);
        add(0, 658, 0, 8'h3C, 0, 1, 8'h00);
        add(0, 753, 0, 8'h3C, 0, 1, 8'h00);
        add(0, 754, 0, 8'h3C, 1, 1, 8'h00);
        // u1: 16x8 frame, PIPE_LAT=2, outputs show coordinate 3 ticks back
        add(1, 12, 0, 8'h00, 1, 1, 8'h00);
        add(1, 13, 0, 8'h00, 0, 1, 8'h00);
        add(1, 15, 0, 8'h00, 0, 1, 8'h00);
        add(1,  0, 1, 8'h00, 1, 1, 8'h00);
        add(1,  5, 1, 8'h00, 1, 1, 8'h02);
        add(1, 10, 2, 8'h00, 1, 1, 8'h07);
        add(1, 11, 2, 8'h00, 1, 1, 8'h00);
        add(1,  7, 3, 8'h00, 1, 1, 8'h04);
        add(1,  4, 4, 8'h00, 1, 1, 8'h00);
        add(1,  2, 5, 8'h00, 1, 1, 8'h00);
        add(1,  3, 5, 8'h00, 1, 0, 8'h00);
        add(1,  2, 7, 8'h00, 1, 0, 8'h00);
        add(1,  3, 7, 8'h00, 1, 1, 8'h00);
        // u2: CLK_DIV=1, active-high syncs, PIPE_LAT=0 -> offset 1 tick
        add(2, 10, 0, 8'hC3, 0, 0, 8'h00);
        add(2, 11, 0, 8'hC3, 1, 0, 8'h00);
        add(2, 13, 0, 8'hC3, 1, 0, 8'h00);
        add(2, 14, 0, 8'hC3, 0, 0, 8'h00);
        add(2,  5, 1, 8'hC3, 0, 0, 8'hC3);
        add(2,  9, 1, 8'hC3, 0, 0, 8'h00);
        add(2,  1, 3, 8'h5A, 0, 0, 8'h5A);
        add(2,  0, 4, 8'h5A, 0, 0, 8'h00);
        add(2,  0, 5, 8'h5A, 0, 0, 8'h00);
        add(2,  1, 5, 8'h5A, 0, 1, 8'h00);
        add(2,  0, 7, 8'h5A, 0, 1, 8'h00);
        add(2,  1, 7, 8'h5A, 0, 0, 8'h00);

        repeat (3) @(negedge clk);
        check("rst col0", col0, 0);
        check("rst hs0", hs0, 1);
        check("rst vs0", vs0, 1);
        check("rst fs0", fs0, 0);
        check("rst x0", x0, 0);
        check("rst y0", y0, 0);
        check("rst blink0", bl0, 0);
        check("rst tick0", tick0, 0);
        check("rst hs2", hs2, 0);
        check("rst vs2", vs2, 0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            if (tbl[k].dut == 0) cin0 = tbl[k].cin;
            if (tbl[k].dut == 2) cin2 = tbl[k].cin;
            wait_pos(tbl[k].dut, tbl[k].x, tbl[k].y, (tbl[k].dut == 0) ? 4000 : 600, ok);
            if (!ok) begin
                timeout($sformatf("vec%0d pos", k));
            end else begin
                check($sformatf("vec%0d d%0d(%0d,%0d) hs", k, tbl[k].dut, tbl[k].x, tbl[k].y),
                      get_hs(tbl[k].dut), tbl[k].hs);
                check($sformatf("vec%0d d%0d(%0d,%0d) vs", k, tbl[k].dut, tbl[k].x, tbl[k].y),
                      get_vs(tbl[k].dut), tbl[k].vs);
                check($sformatf("vec%0d d%0d(%0d,%0d) col", k, tbl[k].dut, tbl[k].x, tbl[k].y),
                      get_col(tbl[k].dut), tbl[k].col);
            end
        end

        // u0 pixel_tick period and single-cycle width
        n = 0;
        while (!tick0 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!tick0 && n < 20);
        check("tick0 period", n, 4);

        // u0 horizontal wrap 799 -> 0 with vcnt advance
        wait_pos(0, 799, 2, 20000, ok);
        if (!ok) timeout("wrap0 pos");
        n = 0;
        while (x0 == 11'd799 && n < 10) begin @(negedge clk); n++; end
        check("wrap0 x", x0, 0);
        check("wrap0 y", y0, 3);

        // mid-frame reset on u0 at (300,3)
        wait_pos(0, 300, 3, 6000, ok);
        if (!ok) timeout("mid rst pos");
        check("pre-rst col0", col0, 8'h3C);
        rst_n = 1'b0;
        #1;
        check("mid rst col0", col0, 0);
        check("mid rst x0", x0, 0);
        check("mid rst y0", y0, 0);
        check("mid rst hs0", hs0, 1);
        check("mid rst vs0", vs0, 1);
        check("mid rst tick0", tick0, 0);
        check("mid rst hs2", hs2, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel x0", x0, 0);
        check("rel y0", y0, 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (x0 != 11'd1 && n < 20);
        check("first tick clocks", n, 4);

        // u1 frame_start alignment, period and blink every 2nd frame
        check("blink1 init", bl1, 0);
        wait_fs(1, ok);
        if (!ok) timeout("fs1 #1");
        check("fs1 x", x1, 15);
        check("fs1 y", y1, 7);
        check("fs1 tick", tick1, 1);
        @(negedge clk);
        check("fs1 width", fs1, 0);
        check("blink1 after fs1", bl1, 0);
        n = 1;
        while (!fs1 && n < 1000) begin @(negedge clk); n++; end
        check("fs1 period", n, 256);
        @(negedge clk);
        check("blink1 after fs2", bl1, 1);
        wait_fs(1, ok);
        if (!ok) timeout("fs1 #3");
        @(negedge clk);
        check("blink1 after fs3", bl1, 1);
        wait_fs(1, ok);
        if (!ok) timeout("fs1 #4");
        @(negedge clk);
        check("blink1 after fs4", bl1, 0);

        // u2: tick stuck high, frame period in clocks equals tick count
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tick2) n++;
        end
        check("tick2 low count", n, 0);
        wait_fs(2, ok);
        if (!ok) timeout("fs2 #1");
        check("fs2 x", x2, 15);
        check("fs2 y", y2, 7);
        n = 0;
        do begin @(negedge clk); n++; end while (!fs2 && n < 1000);
        check("fs2 period", n, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
